pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Stall/flush sequencer for the 5-stage RV32 pipeline.
- Drives the active-high stall (register `en`) and synchronous clear (register `clr`) inputs of the F, F/D, D/E, E/M and M/W pipeline registers.
- Owns the data-memory valid/ready handshake for the M stage, resolves load-use and branch hazards, and enforces a bounded memory-wait timeout that freezes the core on error.

Parameters:
- TIMEOUT_CYCLES, 256, maximum cycles one data-memory access may wait for `dmem_ready` before error; legal range 2..65535.
- CNT_W, 16, width of the internal wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_read_m  in  1  instruction in M is a load.
- mem_write_m  in  1  instruction in M is a store.
- dmem_ready  in  1  memory accepts/completes the current access this cycle.
- result_src_e  in  2  writeback select of the instruction in E; 2'b01 = load.
- rd_e  in  5  destination register of the instruction in E.
- rs1_d, rs2_d  in  5 each  source registers of the instruction in D.
- pc_src_e  in  1  branch/jump taken in E.
- dmem_valid  out  1  memory request valid.
- stall_f, stall_d, stall_e, stall_m, stall_w  out  1 each  hold the corresponding pipeline register.
- flush_d, flush_e, flush_w  out  1 each  clear the corresponding pipeline register to a bubble.
- mem_err  out  1  sticky timeout error.

Behaviour:
- FSM states: IDLE, MEM_WAIT, ERR. Registered state plus wait counter `wcnt`; all other outputs are combinational from state and inputs.
- `acc = mem_read_m | mem_write_m`.
- IDLE:
  - `dmem_valid = acc`.
  - If `acc & dmem_ready`: access completes this cycle, no stall, stay in IDLE.
  - If `acc & !dmem_ready`: mem stall this cycle, go to MEM_WAIT, `wcnt <= 1`.
- MEM_WAIT:
  - `dmem_valid = 1`, held stable until ready.
  - If `dmem_ready`: no stall this cycle, M/W captures, go to IDLE.
  - Else, if `wcnt == TIMEOUT_CYCLES-1`: go to ERR.
  - Else `wcnt <= wcnt+1`.
- ERR:
  - `mem_err = 1`, `dmem_valid = 0`, all five stalls = 1, `flush_w = 1`.
  - Leaves only on reset.
- Mem stall (IDLE with `acc & !dmem_ready`, or MEM_WAIT with `!dmem_ready`):
  - `stall_f/d/e/m = 1`, `stall_w = 0`, `flush_w = 1`. A bubble enters W, so an instruction is never written back twice.
  - Load-use and branch flushes are suppressed. The E-stage instruction is held, so its hazard re-evaluates on release.
- Load-use (no mem stall):
  - `lu = (result_src_e == 2'b01) & (rd_e != 0) & ((rd_e == rs1_d) | (rd_e == rs2_d))`.
  - `lu` gives `stall_f = stall_d = 1`, `flush_e = 1`.
- Branch (no mem stall): `pc_src_e` gives `flush_d = 1`, `flush_e = 1`.
- Simultaneous `lu & pc_src_e`:
  - Flushes win: `flush_d = flush_e = 1`, `stall_f = stall_d = 0`.
  - The load-use instruction in D is squashed anyway.
- Outputs not otherwise asserted are 0.
- Reset (async assert, sync release):
  - State = IDLE, `wcnt = 0`, `mem_err = 0`.
  - While `rst_n = 0`: `flush_d = flush_e = flush_w = 1`, all stalls 0, `dmem_valid = 0`, independent of inputs.
  - Reset during MEM_WAIT abandons the access; `dmem_valid` drops immediately.
- A write to x0 (`rd_e = 0`) never causes a load-use stall.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined:
  - Adds outputs `perf_mem_stall` (32-bit) and `perf_lu_stall` (32-bit), plus input `perf_clr` (1-bit, sync).
  - `perf_mem_stall` increments on each mem-stall cycle; `perf_lu_stall` increments on each cycle with `lu` applied (not overridden).
  - Both saturate at 32'hFFFF_FFFF and reset to 0 on `rst_n = 0` or `perf_clr = 1`. `perf_clr` has priority over increment.
- Undefined: these ports and counters do not exist; behaviour otherwise identical.

Test Plan:
- Reset: hold `rst_n = 0` with `mem_read_m = 1`, `pc_src_e = 1` -> `flush_d/e/w = 1`, stalls 0, `dmem_valid = 0`, `mem_err = 0`.
- Zero-wait load: `mem_read_m = 1`, `dmem_ready = 1` same cycle -> `dmem_valid = 1`, no stall, state stays IDLE.
- Three-wait store: `mem_write_m = 1`, `dmem_ready` low 3 cycles then high -> `stall_f..m = 1` and `flush_w = 1` for exactly 3 cycles; release on the 4th cycle; `dmem_valid` stays high through all 4 cycles.
- Load-use: `result_src_e = 01`, `rd_e = 5`, `rs2_d = 5` -> `stall_f = stall_d = flush_e = 1`. Repeat with `rd_e = 0` -> no stall.
- Branch during mem wait: `pc_src_e = 1` while MEM_WAIT -> `flush_d = flush_e = 0`; on the ready cycle `flush_d = flush_e = 1`.
- Timeout with TIMEOUT_CYCLES = 4: `mem_read_m = 1`, `dmem_ready` stuck 0 -> enter ERR after 4 stall cycles, `mem_err = 1`, all stalls 1. Pulse `rst_n` -> IDLE, `mem_err = 0`.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline: M-stage memory handshake,
// load-use and branch hazards, memory-wait timeout. Optional perf counters: HAZARD_PERF_EN.
module pipe_hazard_ctrl #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read_m,
  input  logic        mem_write_m,
  input  logic        dmem_ready,
  input  logic [1:0]  result_src_e,
  input  logic [4:0]  rd_e,
  input  logic [4:0]  rs1_d,
  input  logic [4:0]  rs2_d,
  input  logic        pc_src_e,
  output logic        dmem_valid,
  output logic        stall_f,
  output logic        stall_d,
  output logic        stall_e,
  output logic        stall_m,
  output logic        stall_w,
  output logic        flush_d,
  output logic        flush_e,
  output logic        flush_w,
`ifdef HAZARD_PERF_EN
  input  logic        perf_clr,
  output logic [31:0] perf_mem_stall,
  output logic [31:0] perf_lu_stall,
`endif
  output logic        mem_err
);

  typedef enum logic [1:0] {IDLE, MEM_WAIT, ERR} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   wcnt_q, wcnt_d;
  logic               acc, lu, mem_stall, lu_apply;

  assign acc = mem_read_m | mem_write_m;
  assign lu  = (result_src_e == 2'b01) && (rd_e != 5'd0) &&
               ((rd_e == rs1_d) || (rd_e == rs2_d));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    mem_stall  = 1'b0;
    lu_apply   = 1'b0;
    dmem_valid = 1'b0;
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    stall_e    = 1'b0;
    stall_m    = 1'b0;
    stall_w    = 1'b0;
    flush_d    = 1'b0;
    flush_e    = 1'b0;
    flush_w    = 1'b0;
    mem_err    = 1'b0;

    case (state_q)
      IDLE: begin
        dmem_valid = acc;
        if (acc && !dmem_ready) begin
          mem_stall = 1'b1;
          state_d   = MEM_WAIT;
          wcnt_d    = CNT_W'(1);
        end
      end
      MEM_WAIT: begin
        dmem_valid = 1'b1;
        if (dmem_ready) begin
          state_d = IDLE;
          wcnt_d  = '0;
        end else begin
          mem_stall = 1'b1;
          if (wcnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) state_d = ERR;
          else                                     wcnt_d  = wcnt_q + CNT_W'(1);
        end
      end
      ERR: begin
        mem_err = 1'b1;
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        stall_w = 1'b1;
        flush_w = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // A held E stage re-evaluates its hazards once the memory stall releases.
    if (state_q != ERR) begin
      if (mem_stall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
      end else if (pc_src_e) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (lu) begin
        stall_f  = 1'b1;
        stall_d  = 1'b1;
        flush_e  = 1'b1;
        lu_apply = 1'b1;
      end
    end

    // Reset bubbles the whole pipe regardless of state or inputs.
    if (!rst_n) begin
      mem_stall  = 1'b0;
      lu_apply   = 1'b0;
      dmem_valid = 1'b0;
      stall_f    = 1'b0;
      stall_d    = 1'b0;
      stall_e    = 1'b0;
      stall_m    = 1'b0;
      stall_w    = 1'b0;
      flush_d    = 1'b1;
      flush_e    = 1'b1;
      flush_w    = 1'b1;
      mem_err    = 1'b0;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] pm_q, pl_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pm_q <= '0;
      pl_q <= '0;
    end else if (perf_clr) begin
      pm_q <= '0;
      pl_q <= '0;
    end else begin
      if (mem_stall && pm_q != 32'hFFFF_FFFF) pm_q <= pm_q + 32'd1;
      if (lu_apply  && pl_q != 32'hFFFF_FFFF) pl_q <= pl_q + 32'd1;
    end
  end

  assign perf_mem_stall = pm_q;
  assign perf_lu_stall  = pl_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized bench for pipe_hazard_ctrl against a rule-level model (TIMEOUT_CYCLES = 4).
module tb_pipe_hazard_ctrl;
  localparam int T = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mem_read_m, mem_write_m, dmem_ready, pc_src_e;
  logic [1:0] result_src_e;
  logic [4:0] rd_e, rs1_d, rs2_d;
  logic       dmem_valid, stall_f, stall_d, stall_e, stall_m, stall_w;
  logic       flush_d, flush_e, flush_w, mem_err;
`ifdef HAZARD_PERF_EN
  logic        perf_clr = 1'b0;
  logic [31:0] perf_mem_stall, perf_lu_stall;
  longint      m_pm, m_pl;
`endif

  int checks = 0, failures = 0;

  // model: count of consecutive memory-stall cycles and a sticky error flag
  int m_waited;
  bit m_err;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.TIMEOUT_CYCLES(T), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read_m(mem_read_m), .mem_write_m(mem_write_m),
    .dmem_ready(dmem_ready), .result_src_e(result_src_e), .rd_e(rd_e),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .pc_src_e(pc_src_e), .dmem_valid(dmem_valid),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .stall_w(stall_w), .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
`ifdef HAZARD_PERF_EN
    .perf_clr(perf_clr), .perf_mem_stall(perf_mem_stall), .perf_lu_stall(perf_lu_stall),
`endif
    .mem_err(mem_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_lu();
    return (result_src_e == 2'b01) && (rd_e != 0) && (rd_e == rs1_d || rd_e == rs2_d);
  endfunction

  function automatic bit is_mstall();
    return !m_err && (m_waited > 0 || mem_read_m || mem_write_m) && !dmem_ready;
  endfunction

  // {valid, sf, sd, se, sm, sw, fd, fe, fw, err}
  function automatic logic [9:0] expect_outs();
    if (!rst_n)       return 10'b0_00000_111_0;
    if (m_err)        return 10'b0_11111_001_1;
    begin
      logic v;
      v = (m_waited > 0) || mem_read_m || mem_write_m;
      if (is_mstall()) return {v, 5'b11110, 3'b001, 1'b0};
      if (pc_src_e)    return {v, 5'b00000, 3'b110, 1'b0};
      if (is_lu())     return {v, 5'b11000, 3'b010, 1'b0};
      return {v, 9'b0};
    end
  endfunction

  task automatic model_reset();
    m_waited = 0;
    m_err    = 0;
`ifdef HAZARD_PERF_EN
    m_pm = 0; m_pl = 0;
`endif
  endtask

  // Inputs are applied just after a rising edge; outputs checked on the falling edge.
  task automatic cyc(input bit rn, input bit mr, input bit mw, input bit rdy,
                     input logic [1:0] rs, input logic [4:0] rde, input logic [4:0] r1,
                     input logic [4:0] r2, input bit pc, input string tag);
    rst_n = rn; mem_read_m = mr; mem_write_m = mw; dmem_ready = rdy;
    result_src_e = rs; rd_e = rde; rs1_d = r1; rs2_d = r2; pc_src_e = pc;
    if (!rn) model_reset();
    @(negedge clk);
    chk(tag, {dmem_valid, stall_f, stall_d, stall_e, stall_m, stall_w,
              flush_d, flush_e, flush_w, mem_err}, expect_outs());
`ifdef HAZARD_PERF_EN
    chk({tag, "_pm"}, perf_mem_stall, m_pm[31:0]);
    chk({tag, "_pl"}, perf_lu_stall,  m_pl[31:0]);
`endif
    @(posedge clk);
    if (rst_n) begin
`ifdef HAZARD_PERF_EN
      if (perf_clr) begin
        m_pm = 0; m_pl = 0;
      end else begin
        if (is_mstall() && m_pm < 64'hFFFF_FFFF) m_pm++;
        if (!m_err && !is_mstall() && !pc_src_e && is_lu() && m_pl < 64'hFFFF_FFFF) m_pl++;
      end
`endif
      if (!m_err) begin
        if (is_mstall()) begin
          m_waited++;
          if (m_waited == T) begin
            m_err = 1; m_waited = 0;
          end
        end else m_waited = 0;
      end
    end
    #1;
  endtask

  initial begin
    model_reset();
    // reset holds outputs regardless of active inputs
    cyc(0, 1, 0, 0, 2'b01, 5'd5, 5'd5, 5'd0, 1, "reset");
    cyc(0, 1, 0, 0, 2'b01, 5'd5, 5'd5, 5'd0, 1, "reset2");
    // zero-wait load
    cyc(1, 1, 0, 1, 2'b00, 5'd0, 5'd0, 5'd0, 0, "load0");
    // three-wait store, release on the fourth cycle
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0, 2'b00, 5'd0, 5'd0, 5'd0, 0, "store_wait");
    cyc(1, 0, 1, 1, 2'b00, 5'd0, 5'd0, 5'd0, 0, "store_rel");
    // load-use, then same with x0
    cyc(1, 0, 0, 1, 2'b01, 5'd5, 5'd1, 5'd5, 0, "lu");
    cyc(1, 0, 0, 1, 2'b01, 5'd0, 5'd0, 5'd0, 0, "lu_x0");
    // branch during memory wait, then on ready; lu together with branch
    cyc(1, 1, 0, 0, 2'b01, 5'd3, 5'd3, 5'd0, 1, "br_wait");
    cyc(1, 1, 0, 0, 2'b01, 5'd3, 5'd3, 5'd0, 1, "br_wait2");
    cyc(1, 1, 0, 1, 2'b01, 5'd3, 5'd3, 5'd0, 1, "br_rel");
    // timeout: four stall cycles then sticky error
    for (int i = 0; i < T; i++) cyc(1, 1, 0, 0, 2'b00, 5'd0, 5'd0, 5'd0, 0, "to_wait");
    chk("err_entered", mem_err, 1'b1);
    cyc(1, 0, 0, 1, 2'b01, 5'd2, 5'd2, 5'd0, 1, "err_hold");
    cyc(0, 1, 0, 0, 2'b00, 5'd0, 5'd0, 5'd0, 0, "err_rst");
    cyc(1, 0, 0, 0, 2'b00, 5'd0, 5'd0, 5'd0, 0, "post_rst");
    chk("err_cleared", mem_err, 1'b0);
    // reset during a wait abandons the access
    cyc(1, 0, 1, 0, 2'b00, 5'd0, 5'd0, 5'd0, 0, "mw_pre");
    cyc(0, 0, 1, 0, 2'b00, 5'd0, 5'd0, 5'd0, 0, "mw_rst");
    cyc(1, 0, 0, 0, 2'b00, 5'd0, 5'd0, 5'd0, 0, "mw_post");

    for (int n = 0; n < 3000; n++) begin
      bit rn, mr, mw;
`ifdef HAZARD_PERF_EN
      perf_clr = ($urandom_range(0, 99) == 0);
`endif
      rn = ($urandom_range(0, 79) != 0);
      mr = ($urandom_range(0, 3) == 0);
      mw = !mr && ($urandom_range(0, 4) == 0);
      cyc(rn, mr, mw, ($urandom_range(0, 9) < 6),
          2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          ($urandom_range(0, 5) == 0), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
